fifo_uart_tx: RTL

Downstream consumer of the RAM-to-FIFO path. Pops 16-bit words from the 16-bit-wide FIFO that `data_mover` fills and transmits each word as two 8N1 UART bytes on a single serial line, high byte first. Sits between the FIFO read port and the board's serial pin. Replaces the always-read sink used during bring-up.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/baud_counter.sv | 29 ++
 rtl/fifo_uart_tx.sv | 88 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encoding,
// frame geometry and the baud divisor derivation.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    LOAD = 2'd2,
    SEND = 2'd3
  } state_t;

  localparam int FRAME_BITS  = 10;
  localparam int WORD_FRAMES = 2;
  localparam int WORD_BITS   = FRAME_BITS * WORD_FRAMES;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
// Holding clear parks the count at zero so the first bit starts a full period.
module baud_counter #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clock,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = !clear && (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops 16-bit words from a non-show-ahead FIFO and sends each as two 8N1
// bytes, high byte first, on a registered serial line.
//
// state | meaning
// IDLE  | line high, waiting for enable with a non-empty FIFO
// POP   | one-cycle FIFO read request
// LOAD  | FIFO q valid; frame register captured at the closing edge
// SEND  | shifting the 20-bit two-byte frame out LSB first
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 500,
  parameter int BAUD_RATE = 50
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] fifo_data_in,
  input  logic        fifo_empty,
  output logic        fifo_rdreq,
  output logic        tx,
  output logic        busy
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);

  state_t                 state, state_next;
  logic [WORD_BITS-1:0]   frame, frame_next;
  logic [4:0]             bit_idx, bit_idx_next;
  logic                   tx_next;
  logic                   tick;
  logic                   last_bit;

  baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clock (clock),
    .rst   (rst),
    .clear (state != SEND),
    .tick  (tick)
  );

  assign last_bit = (bit_idx == 5'(WORD_BITS - 1));

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      frame   <= '1;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      frame   <= frame_next;
      bit_idx <= bit_idx_next;
      tx      <= tx_next;
    end
  end

  always_comb begin
    state_next   = state;
    frame_next   = frame;
    bit_idx_next = bit_idx;
    case (state)
      IDLE: if (enable && !fifo_empty) state_next = POP;
      POP:  state_next = LOAD;
      LOAD: begin
        // Two frames back to back; the low half goes out first, so it holds hi.
        frame_next   = {1'b1, fifo_data_in[7:0], 1'b0, 1'b1, fifo_data_in[15:8], 1'b0};
        bit_idx_next = '0;
        state_next   = SEND;
      end
      SEND: begin
        if (tick) begin
          frame_next   = {1'b1, frame[WORD_BITS-1:1]};
          bit_idx_next = bit_idx + 5'd1;
          if (last_bit) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Registering the next line value keeps tx glitch-free and input-isolated.
    tx_next = (state_next == SEND) ? frame_next[0] : 1'b1;
  end

  always_comb begin
    fifo_rdreq = (state == POP);
    busy       = (state != IDLE);
  end

endmodule
